// File: rtl/vy_blok_yanitlayici_pkg.sv
// rtl/vy_blok_yanitlayici_pkg.sv - shared state type for the block responder
package vy_blok_yanitlayici_pkg;
`include "sabitler.vh"

    typedef enum logic [2:0] {
        BOSTA     = `VY_YNT_BOSTA,
        OKU_ISTEK = `VY_YNT_OKU_ISTEK,
        OKU_BEKLE = `VY_YNT_OKU_BEKLE,
        YANIT     = `VY_YNT_YANIT,
        YAZ_ISTEK = `VY_YNT_YAZ_ISTEK
    } durum_t;

endpackage

// File: rtl/sabitler.vh
// rtl/sabitler.vh - state encodings and default widths for vy_blok_yanitlayici
`ifndef VY_SABITLER_VH
`define VY_SABITLER_VH

`define VY_YNT_BOSTA      3'd0
`define VY_YNT_OKU_ISTEK  3'd1
`define VY_YNT_OKU_BEKLE  3'd2
`define VY_YNT_YANIT      3'd3
`define VY_YNT_YAZ_ISTEK  3'd4

`define VY_ADRES_BIT      32
`define VY_BLOK_BIT       128
`define VY_BELLEK_BIT     32
`define VY_ZAMAN_ASIMI    255

`endif

// File: rtl/vy_blok_yanitlayici.sv
// rtl/vy_blok_yanitlayici.sv - L1 block fill/write-back responder over a narrow memory port; optional read timeout via VY_ZAMAN_ASIMI_EN
`include "sabitler.vh"

module vy_blok_yanitlayici
    import vy_blok_yanitlayici_pkg::*;
#(
    parameter int ADRES_BIT   = `VY_ADRES_BIT,
    parameter int BLOK_BIT    = `VY_BLOK_BIT,
    parameter int BELLEK_BIT  = `VY_BELLEK_BIT,
    parameter int ZAMAN_ASIMI = `VY_ZAMAN_ASIMI
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [ADRES_BIT-1:0]  l1_istek_adres_i,
    input  logic                  l1_istek_gecerli_i,
    input  logic                  l1_istek_yaz_i,
    input  logic [BLOK_BIT-1:0]   l1_istek_veri_i,
    output logic                  l1_istek_hazir_o,
    output logic [BLOK_BIT-1:0]   l1_veri_o,
    output logic                  l1_veri_gecerli_o,
    output logic                  l1_veri_hata_o,
    input  logic                  l1_veri_hazir_i,
    output logic [ADRES_BIT-1:0]  bellek_istek_adres_o,
    output logic                  bellek_istek_gecerli_o,
    output logic                  bellek_istek_yaz_o,
    output logic [BELLEK_BIT-1:0] bellek_istek_veri_o,
    input  logic                  bellek_istek_hazir_i,
    input  logic [BELLEK_BIT-1:0] bellek_veri_i,
    input  logic                  bellek_veri_gecerli_i,
    output logic                  bellek_veri_hazir_o
);

    localparam int N       = BLOK_BIT / BELLEK_BIT;
    localparam int OFS_BIT = $clog2(BLOK_BIT / 8);
    localparam int KW      = (N > 1) ? $clog2(N) : 1;

    localparam logic [ADRES_BIT-1:0] TABAN_MASKE = ~((ADRES_BIT'(1) << OFS_BIT) - ADRES_BIT'(1));
    localparam logic [ADRES_BIT-1:0] BEAT_BAYT   = ADRES_BIT'(BELLEK_BIT / 8);
    localparam logic [KW-1:0]        SON_K       = KW'(N - 1);

    durum_t                r_durum;
    durum_t                w_durum_sonraki;
    logic [ADRES_BIT-1:0]  r_taban;
    logic [BLOK_BIT-1:0]   r_blok;
    logic [BLOK_BIT-1:0]   r_tampon;
    logic [KW-1:0]         r_k;

    logic                  w_kabul;
    logic                  w_bellek_kabul;
    logic                  w_veri_al;
    logic                  w_son;
    logic                  w_zaman_doldu;
    logic [ADRES_BIT-1:0]  w_beat_adres;
    logic [BELLEK_BIT-1:0] w_yaz_dilim;

    // Beat address wraps naturally at ADRES_BIT because the sum is truncated.
    assign w_beat_adres   = r_taban + ADRES_BIT'(r_k) * BEAT_BAYT;
    assign w_yaz_dilim    = r_blok[int'(r_k) * BELLEK_BIT +: BELLEK_BIT];
    assign w_son          = (r_k == SON_K);
    assign w_kabul        = l1_istek_gecerli_i & l1_istek_hazir_o;
    assign w_bellek_kabul = (r_durum == OKU_ISTEK) & bellek_istek_hazir_i;
    assign w_veri_al      = (r_durum == OKU_BEKLE) & bellek_veri_gecerli_i;
    assign l1_veri_o      = r_tampon;

`ifdef VY_ZAMAN_ASIMI_EN
    logic [31:0] r_sayac;
    logic        r_hata;

    assign w_zaman_doldu  = (r_sayac == 32'(ZAMAN_ASIMI - 1));
    assign l1_veri_hata_o = r_hata;

    // Idle-cycle counter for the read path; a beat handshake restarts it at one so
    // that it equals ZAMAN_ASIMI on the edge that enters YANIT.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sayac <= '0;
        end else if (r_durum == OKU_ISTEK || r_durum == OKU_BEKLE) begin
            if (w_bellek_kabul || w_veri_al) begin
                r_sayac <= 32'd1;
            end else if (w_zaman_doldu) begin
                r_sayac <= '0;
            end else begin
                r_sayac <= r_sayac + 32'd1;
            end
        end else begin
            r_sayac <= '0;
        end
    end

    // Error flag lives for the duration of the timed-out response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_hata <= 1'b0;
        end else if ((r_durum == OKU_ISTEK && !w_bellek_kabul && w_zaman_doldu) ||
                     (r_durum == OKU_BEKLE && !w_veri_al && w_zaman_doldu)) begin
            r_hata <= 1'b1;
        end else if (r_durum == YANIT && l1_veri_hazir_i) begin
            r_hata <= 1'b0;
        end
    end
`else
    assign w_zaman_doldu  = 1'b0;
    assign l1_veri_hata_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_durum_sonraki;
        end
    end

    // Next state and state-decoded outputs; nothing here passes an input straight to an output.
    always_comb begin
        w_durum_sonraki        = r_durum;
        l1_istek_hazir_o       = 1'b0;
        l1_veri_gecerli_o      = 1'b0;
        bellek_istek_gecerli_o = 1'b0;
        bellek_istek_yaz_o     = 1'b0;
        bellek_istek_adres_o   = '0;
        bellek_istek_veri_o    = '0;
        bellek_veri_hazir_o    = 1'b0;
        case (r_durum)
            BOSTA: begin
                l1_istek_hazir_o = 1'b1;
                if (l1_istek_gecerli_i) begin
                    w_durum_sonraki = l1_istek_yaz_i ? YAZ_ISTEK : OKU_ISTEK;
                end
            end
            OKU_ISTEK: begin
                bellek_istek_gecerli_o = 1'b1;
                bellek_istek_adres_o   = w_beat_adres;
                if (bellek_istek_hazir_i) begin
                    w_durum_sonraki = OKU_BEKLE;
                end else if (w_zaman_doldu) begin
                    w_durum_sonraki = YANIT;
                end
            end
            OKU_BEKLE: begin
                bellek_veri_hazir_o = 1'b1;
                if (bellek_veri_gecerli_i) begin
                    w_durum_sonraki = w_son ? YANIT : OKU_ISTEK;
                end else if (w_zaman_doldu) begin
                    w_durum_sonraki = YANIT;
                end
            end
            YANIT: begin
                l1_veri_gecerli_o = 1'b1;
                if (l1_veri_hazir_i) begin
                    w_durum_sonraki = BOSTA;
                end
            end
            YAZ_ISTEK: begin
                bellek_istek_gecerli_o = 1'b1;
                bellek_istek_yaz_o     = 1'b1;
                bellek_istek_adres_o   = w_beat_adres;
                bellek_istek_veri_o    = w_yaz_dilim;
                if (bellek_istek_hazir_i && w_son) begin
                    w_durum_sonraki = BOSTA;
                end
            end
            default: begin
                w_durum_sonraki = BOSTA;
            end
        endcase
    end

    // Request capture, beat counter and read-assembly buffer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_taban  <= '0;
            r_blok   <= '0;
            r_tampon <= '0;
            r_k      <= '0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    if (w_kabul) begin
                        r_taban <= l1_istek_adres_i & TABAN_MASKE;
                        r_blok  <= l1_istek_veri_i;
                        r_k     <= '0;
                    end
                end
                OKU_ISTEK: begin
                    if (!bellek_istek_hazir_i && w_zaman_doldu) begin
                        r_tampon <= '0;
                    end
                end
                OKU_BEKLE: begin
                    if (bellek_veri_gecerli_i) begin
                        r_tampon[int'(r_k) * BELLEK_BIT +: BELLEK_BIT] <= bellek_veri_i;
                        if (!w_son) begin
                            r_k <= r_k + KW'(1);
                        end
                    end else if (w_zaman_doldu) begin
                        r_tampon <= '0;
                    end
                end
                YAZ_ISTEK: begin
                    if (bellek_istek_hazir_i && !w_son) begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vy_blok_yanitlayici.sv
// tb/tb_vy_blok_yanitlayici.sv - scoreboard bench for vy_blok_yanitlayici
`timescale 1ns/1ps

module tb_vy_blok_yanitlayici;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [31:0]  l1_istek_adres_i;
    logic         l1_istek_gecerli_i;
    logic         l1_istek_yaz_i;
    logic [127:0] l1_istek_veri_i;
    logic         l1_istek_hazir_o;
    logic [127:0] l1_veri_o;
    logic         l1_veri_gecerli_o;
    logic         l1_veri_hata_o;
    logic         l1_veri_hazir_i;
    logic [31:0]  bellek_istek_adres_o;
    logic         bellek_istek_gecerli_o;
    logic         bellek_istek_yaz_o;
    logic [31:0]  bellek_istek_veri_o;
    logic         bellek_istek_hazir_i;
    logic [31:0]  bellek_veri_i;
    logic         bellek_veri_gecerli_i;
    logic         bellek_veri_hazir_o;

    always #5 clk_i = ~clk_i;

    vy_blok_yanitlayici #(
        .ADRES_BIT   (32),
        .BLOK_BIT    (128),
        .BELLEK_BIT  (32),
        .ZAMAN_ASIMI (10)
    ) dut (
        .clk_i                  (clk_i),
        .rstn_i                 (rstn_i),
        .l1_istek_adres_i       (l1_istek_adres_i),
        .l1_istek_gecerli_i     (l1_istek_gecerli_i),
        .l1_istek_yaz_i         (l1_istek_yaz_i),
        .l1_istek_veri_i        (l1_istek_veri_i),
        .l1_istek_hazir_o       (l1_istek_hazir_o),
        .l1_veri_o              (l1_veri_o),
        .l1_veri_gecerli_o      (l1_veri_gecerli_o),
        .l1_veri_hata_o         (l1_veri_hata_o),
        .l1_veri_hazir_i        (l1_veri_hazir_i),
        .bellek_istek_adres_o   (bellek_istek_adres_o),
        .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
        .bellek_istek_yaz_o     (bellek_istek_yaz_o),
        .bellek_istek_veri_o    (bellek_istek_veri_o),
        .bellek_istek_hazir_i   (bellek_istek_hazir_i),
        .bellek_veri_i          (bellek_veri_i),
        .bellek_veri_gecerli_i  (bellek_veri_gecerli_i),
        .bellek_veri_hazir_o    (bellek_veri_hazir_o)
    );

    int           n_kontrol = 0;
    int           n_hata    = 0;
    logic [31:0]  q_adr[$];
    logic [31:0]  q_veri[$];
    logic [127:0] q_blok[$];
    logic [31:0]  rd_data[4];

    task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
        n_kontrol++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic reset_kontrol();
        kontrol("rst_istek_hazir", l1_istek_hazir_o, 1);
        kontrol("rst_l1_gecerli", l1_veri_gecerli_o, 0);
        kontrol("rst_l1_veri", l1_veri_o, 0);
        kontrol("rst_l1_hata", l1_veri_hata_o, 0);
        kontrol("rst_bel_gecerli", bellek_istek_gecerli_o, 0);
        kontrol("rst_bel_yaz", bellek_istek_yaz_o, 0);
        kontrol("rst_bel_adres", bellek_istek_adres_o, 0);
        kontrol("rst_bel_veri", bellek_istek_veri_o, 0);
        kontrol("rst_bel_hazir", bellek_veri_hazir_o, 0);
    endtask

    // One L1 request against a memory model. stall: cycles of hazir low before each
    // beat accept; l1_bekle: cycles L1 holds off the fill; kes: reset after that many
    // read beats (0 = never); kayip: read beat index whose data never comes (-1 = none).
    task automatic islem(input logic yaz, input logic [31:0] adr, input logic [127:0] blk,
                         input int stall, input int l1_bekle, input int kes, input int kayip,
                         input int bek_gecikme, input logic bek_hata);
        logic [31:0]  taban;
        logic [127:0] bek_blok;
        logic [127:0] onceki_blok;
        logic [31:0]  onceki_adr;
        logic [31:0]  onceki_veri;
        logic [31:0]  pend_d;
        logic         onceki_stall;
        logic         pend;
        logic         yanit_goruldu;
        logic         bitti;
        int           c, beat, st, rd_done, wcnt;

        taban = adr & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) begin
            q_adr.push_back(taban + 32'(k * 4));
            q_veri.push_back(yaz ? blk[k*32 +: 32] : 32'h0);
        end
        if (!yaz) begin
            bek_blok = {rd_data[3], rd_data[2], rd_data[1], rd_data[0]};
            if (kayip >= 0) bek_blok = '0;
            q_blok.push_back(bek_blok);
        end

        @(negedge clk_i);
        kontrol("istek_hazir", l1_istek_hazir_o, 1);
        l1_istek_gecerli_i = 1'b1;
        l1_istek_adres_i   = adr;
        l1_istek_yaz_i     = yaz;
        l1_istek_veri_i    = blk;
        @(negedge clk_i);
        // Garbage on the request lines must be ignored once the request is taken.
        l1_istek_gecerli_i = 1'b0;
        l1_istek_adres_i   = 32'hDEAD_BEEF;
        l1_istek_yaz_i     = ~yaz;
        l1_istek_veri_i    = {4{32'hA5A5_5A5A}};

        c = 1; beat = 0; st = 0; rd_done = 0; wcnt = 0;
        pend = 1'b0; pend_d = '0; onceki_stall = 1'b0; onceki_adr = '0; onceki_veri = '0;
        onceki_blok = '0; yanit_goruldu = 1'b0; bitti = 1'b0;

        while (!bitti && c < 300) begin
            if (kes > 0 && rd_done == kes) begin
                rstn_i = 1'b0;
                bellek_veri_gecerli_i = 1'b0;
                bellek_istek_hazir_i  = 1'b0;
                #1;
                reset_kontrol();
                @(negedge clk_i);
                rstn_i = 1'b1;
                q_adr.delete();
                q_veri.delete();
                q_blok.delete();
                bitti = 1'b1;
            end else begin
                if (pend) begin
                    bellek_veri_gecerli_i = 1'b1;
                    bellek_veri_i         = pend_d;
                    if (bellek_veri_hazir_o) begin
                        pend = 1'b0;
                        rd_done++;
                    end
                end else begin
                    bellek_veri_gecerli_i = 1'b0;
                    bellek_veri_i         = 32'h0;
                end

                if (bellek_istek_gecerli_o) begin
                    if (onceki_stall) begin
                        kontrol("stall_adres", bellek_istek_adres_o, onceki_adr);
                        kontrol("stall_veri", bellek_istek_veri_o, onceki_veri);
                    end
                    if (st < stall) begin
                        bellek_istek_hazir_i = 1'b0;
                        st++;
                        onceki_stall = 1'b1;
                        onceki_adr   = bellek_istek_adres_o;
                        onceki_veri  = bellek_istek_veri_o;
                    end else begin
                        bellek_istek_hazir_i = 1'b1;
                        st = 0;
                        onceki_stall = 1'b0;
                        if (q_adr.size() == 0) begin
                            kontrol("fazla_beat", 1, 0);
                        end else begin
                            kontrol("beat_adres", bellek_istek_adres_o, q_adr.pop_front());
                            kontrol("beat_yaz", bellek_istek_yaz_o, yaz);
                            if (yaz) kontrol("beat_veri", bellek_istek_veri_o, q_veri.pop_front());
                            else void'(q_veri.pop_front());
                        end
                        if (!yaz && beat != kayip) begin
                            pend   = 1'b1;
                            pend_d = rd_data[beat];
                        end
                        beat++;
                    end
                end else begin
                    bellek_istek_hazir_i = 1'b0;
                end

                if (yaz) begin
                    if (l1_veri_gecerli_o) kontrol("wb_yanit_yok", 1, 0);
                    if (beat == 4 && l1_istek_hazir_o) begin
                        kontrol("wb_gecikme", c, bek_gecikme);
                        bitti = 1'b1;
                    end
                end else if (l1_veri_gecerli_o) begin
                    if (!yanit_goruldu) begin
                        yanit_goruldu = 1'b1;
                        kontrol("yanit_gecikme", c, bek_gecikme);
                        if (q_blok.size() == 0) kontrol("yanit_fazla", 1, 0);
                        else kontrol("yanit_blok", l1_veri_o, q_blok.pop_front());
                        kontrol("yanit_hata", l1_veri_hata_o, bek_hata);
                        onceki_blok = l1_veri_o;
                    end else begin
                        kontrol("yanit_sabit", l1_veri_o, onceki_blok);
                        kontrol("yanit_istek_yok", l1_istek_hazir_o, 0);
                    end
                    if (wcnt < l1_bekle) begin
                        l1_veri_hazir_i = 1'b0;
                        wcnt++;
                    end else begin
                        l1_veri_hazir_i = 1'b1;
                    end
                end else if (yanit_goruldu) begin
                    kontrol("bosta_donus", l1_istek_hazir_o, 1);
                    l1_veri_hazir_i = 1'b0;
                    bitti = 1'b1;
                end else begin
                    if (l1_istek_hazir_o) kontrol("erken_bosta", 1, 0);
                end
            end
            if (!bitti) begin
                @(negedge clk_i);
                c++;
            end
        end
        if (!bitti) kontrol("zaman_butcesi", 0, 1);
        if (kes == 0 && kayip < 0) kontrol("kuyruk_bos", 128'(q_adr.size()), 0);
        q_adr.delete();
        q_veri.delete();
        q_blok.delete();
        bellek_istek_hazir_i  = 1'b0;
        bellek_veri_gecerli_i = 1'b0;
        l1_veri_hazir_i       = 1'b0;
    endtask

    initial begin
        rstn_i                = 1'b0;
        l1_istek_adres_i      = '0;
        l1_istek_gecerli_i    = 1'b0;
        l1_istek_yaz_i        = 1'b0;
        l1_istek_veri_i       = '0;
        l1_veri_hazir_i       = 1'b0;
        bellek_istek_hazir_i  = 1'b0;
        bellek_veri_i         = '0;
        bellek_veri_gecerli_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_kontrol();
        rstn_i = 1'b1;

        // Zero-wait fill, address inside the block.
        rd_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        islem(1'b0, 32'h1000_0004, '0, 0, 0, 0, -1, 9, 1'b0);

        // Write-back with three stall cycles per beat.
        islem(1'b1, 32'h2000_0010, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 3, 0, 0, -1, 17, 1'b0);

        // Fill with L1 holding off the response for five cycles.
        for (int k = 0; k < 4; k++) rd_data[k] = $urandom;
        islem(1'b0, 32'h3000_0028, '0, 0, 5, 0, -1, 9, 1'b0);

        // Fill at the top of the address space.
        for (int k = 0; k < 4; k++) rd_data[k] = $urandom;
        islem(1'b0, 32'hFFFF_FFF8, '0, 0, 0, 0, -1, 9, 1'b0);

        // Reset after two read beats, then a fresh fill.
        rd_data = '{32'h0BAD_0000, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003};
        islem(1'b0, 32'h4000_0000, '0, 0, 0, 2, -1, 0, 1'b0);
        rd_data = '{32'h5555_0000, 32'h6666_1111, 32'h7777_2222, 32'h8888_3333};
        islem(1'b0, 32'h4000_000C, '0, 1, 0, 0, -1, 13, 1'b0);

`ifdef VY_ZAMAN_ASIMI_EN
        // Beat 1 accepted in cycle 3 and never answered: timeout response in cycle 13.
        rd_data = '{32'h9999_0000, 32'h9999_1111, 32'h9999_2222, 32'h9999_3333};
        islem(1'b0, 32'h5000_0000, '0, 0, 0, 0, 1, 13, 1'b1);
`endif

        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_hata, n_kontrol);
        $finish;
    end

endmodule
